// File: rtl/audio_sample_scheduler.sv
// Stereo PCM scheduler: pair FIFO, priming, divider-timed pcm_valid strobe, underrun handling.
// Optional soft mute on underrun via `define AUDIO_SCHEDULER_SOFT_MUTE_EN.
module audio_sample_scheduler #(
   parameter int WIDTH           = 16,
   parameter int DIVIDER_WIDTH   = 12,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic                       flush,
   input  logic [DIVIDER_WIDTH-1:0]   divider,
   input  logic [WIDTH-1:0]           sample_left,
   input  logic [WIDTH-1:0]           sample_right,
   input  logic                       sample_valid,
   output logic                       sample_ready,
   output logic [WIDTH-1:0]           pcm_left,
   output logic [WIDTH-1:0]           pcm_right,
   output logic                       pcm_valid,
   output logic                       underrun,
   input  logic                       underrun_clear,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam logic [FIFO_DEPTH_LOG2:0]   C_DEPTH   = DEPTH;
   localparam logic [FIFO_DEPTH_LOG2:0]   C_HALF    = DEPTH / 2;
   localparam logic [FIFO_DEPTH_LOG2:0]   C_LVL_ONE = 1;
   localparam logic [FIFO_DEPTH_LOG2-1:0] C_PTR_ONE = 1;
   localparam logic [DIVIDER_WIDTH-1:0]   C_CNT_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

   state_t                     r_state;
   logic [DIVIDER_WIDTH-1:0]   r_cnt;
   logic [WIDTH-1:0]           r_mem_l [DEPTH];
   logic [WIDTH-1:0]           r_mem_r [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] r_wptr;
   logic [FIFO_DEPTH_LOG2-1:0] r_rptr;
   logic [FIFO_DEPTH_LOG2:0]   r_level;
   logic [WIDTH-1:0]           r_pcm_left;
   logic [WIDTH-1:0]           r_pcm_right;
   logic                       r_pcm_valid;
   logic                       r_underrun;

   logic w_push;
   logic w_tick;
   logic w_pop;
   logic w_empty_tick;

`ifdef AUDIO_SCHEDULER_SOFT_MUTE_EN
   // Halve toward zero; -1 would otherwise stick, so it snaps to 0.
   function automatic logic [WIDTH-1:0] f_decay(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] s;
      s = {v[WIDTH-1], v[WIDTH-1:1]};
      return (&s) ? '0 : s;
   endfunction
`endif

   assign sample_ready = reset_n && (r_level != C_DEPTH);
   assign w_push       = sample_valid && sample_ready && !flush;
   assign w_tick       = (r_state == S_RUN) && enable && !flush && (r_cnt == '0);
   assign w_pop        = w_tick && (r_level != '0);
   assign w_empty_tick = w_tick && (r_level == '0);

   assign pcm_left   = r_pcm_left;
   assign pcm_right  = r_pcm_right;
   assign pcm_valid  = r_pcm_valid;
   assign underrun   = r_underrun;
   assign fifo_level = r_level;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_l[r_wptr] <= sample_left;
         r_mem_r[r_wptr] <= sample_right;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + C_PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + C_PTR_ONE;
         if (w_push && !w_pop)      r_level <= r_level + C_LVL_ONE;
         else if (w_pop && !w_push) r_level <= r_level - C_LVL_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else if (flush) begin
         r_state <= enable ? S_PRIME : S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (enable) r_state <= S_PRIME;
            end
            S_PRIME: begin
               if (!enable) begin
                  r_state <= S_IDLE;
               end else if (r_level >= C_HALF) begin
                  r_state <= S_RUN;
                  r_cnt   <= divider;
               end
            end
            S_RUN: begin
               if (!enable) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == '0) begin
                  r_cnt <= divider;
               end else begin
                  r_cnt <= r_cnt - C_CNT_ONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pcm_left  <= '0;
         r_pcm_right <= '0;
         r_pcm_valid <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_pcm_valid <= w_tick;
         if (w_pop) begin
            r_pcm_left  <= r_mem_l[r_rptr];
            r_pcm_right <= r_mem_r[r_rptr];
         end else if (w_empty_tick) begin
`ifdef AUDIO_SCHEDULER_SOFT_MUTE_EN
            r_pcm_left  <= f_decay(r_pcm_left);
            r_pcm_right <= f_decay(r_pcm_right);
`else
            r_pcm_left  <= r_pcm_left;
            r_pcm_right <= r_pcm_right;
`endif
         end
         // set beats a same-cycle clear
         if (w_empty_tick)        r_underrun <= 1'b1;
         else if (underrun_clear) r_underrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Bench for audio_sample_scheduler: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_audio_sample_scheduler;
   localparam int W = 16, DW = 12, L2 = 2, DEPTH = 4;

   logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, flush = 1'b0;
   logic sample_valid = 1'b0, underrun_clear = 1'b0;
   logic [DW-1:0] divider = '0;
   logic [W-1:0]  sample_left = '0, sample_right = '0;
   logic          sample_ready, pcm_valid, underrun;
   logic [W-1:0]  pcm_left, pcm_right;
   logic [L2:0]   fifo_level;

   audio_sample_scheduler #(.WIDTH(W), .DIVIDER_WIDTH(DW), .FIFO_DEPTH_LOG2(L2)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush), .divider(divider),
      .sample_left(sample_left), .sample_right(sample_right), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .pcm_left(pcm_left), .pcm_right(pcm_right),
      .pcm_valid(pcm_valid), .underrun(underrun), .underrun_clear(underrun_clear),
      .fifo_level(fifo_level));

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of pairs, mode 0=idle 1=prime 2=run, cycles-to-tick counter.
   logic [W-1:0] q_l[$], q_r[$];
   int           mode = 0;
   int unsigned  wcnt = 0;
   logic [W-1:0] m_l = '0, m_r = '0;
   logic         m_pv = 1'b0, m_ur = 1'b0;
   int           m_sz;
   bit           m_tk, m_pu;

   function automatic logic [W-1:0] decay(input logic [W-1:0] v);
      int s;
      s = $signed(v);
      s = s >>> 1;
      if (s == -1) s = 0;
      return s[W-1:0];
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_l.delete(); q_r.delete();
         mode = 0; wcnt = 0; m_l = '0; m_r = '0; m_pv = 1'b0; m_ur = 1'b0;
      end else begin
         m_sz = q_l.size();
         m_pu = sample_valid && (m_sz < DEPTH);
         m_tk = (mode == 2) && enable && !flush && (wcnt == 0);
         m_pv = m_tk;
         if (m_tk && m_sz == 0) m_ur = 1'b1;
         else if (underrun_clear) m_ur = 1'b0;
         if (flush) begin
            q_l.delete(); q_r.delete();
            mode = enable ? 1 : 0;
            wcnt = 0;
         end else begin
            if (m_tk) begin
               if (m_sz > 0) begin
                  m_l = q_l.pop_front();
                  m_r = q_r.pop_front();
               end else begin
`ifdef AUDIO_SCHEDULER_SOFT_MUTE_EN
                  m_l = decay(m_l);
                  m_r = decay(m_r);
`endif
               end
            end
            if (m_pu) begin
               q_l.push_back(sample_left);
               q_r.push_back(sample_right);
            end
            if (mode == 0) begin
               wcnt = 0;
               if (enable) mode = 1;
            end else if (mode == 1) begin
               if (!enable) mode = 0;
               else if (m_sz >= DEPTH / 2) begin mode = 2; wcnt = divider; end
            end else begin
               if (!enable) begin mode = 0; wcnt = 0; end
               else wcnt = (wcnt == 0) ? divider : wcnt - 1;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("pcm_valid", pcm_valid, m_pv);
      chk("pcm_left", pcm_left, m_l);
      chk("pcm_right", pcm_right, m_r);
      chk("underrun", underrun, m_ur);
      chk("fifo_level", fifo_level, q_l.size());
      chk("sample_ready", sample_ready, (reset_n && q_l.size() < DEPTH) ? 1 : 0);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pv(output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!pcm_valid && waited < 100);
      total++;
      if (!pcm_valid) begin
         bad++;
         $display("FAIL pv_timeout actual=0 expected=1 at %0t", $time);
      end
   endtask

   task automatic push_one(input logic [W-1:0] l, input logic [W-1:0] r);
      sample_left = l; sample_right = r; sample_valid = 1'b1;
      cyc(1);
      sample_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1; underrun_clear = 1'b1;
      cyc(1);
      flush = 1'b0; underrun_clear = 1'b0;
   endtask

   int n, cnt;

   initial begin
      // reset state
      cyc(2);
      chk("rst_ready", sample_ready, 0);
      chk("rst_pv", pcm_valid, 0);
      chk("rst_left", pcm_left, 0);
      chk("rst_right", pcm_right, 0);
      chk("rst_ur", underrun, 0);
      chk("rst_level", fifo_level, 0);

      // basic delivery, divider=3
      reset_n = 1'b1; divider = 3; enable = 1'b1;
      push_one(16'h1000, 16'hF000);
      push_one(16'h2000, 16'hE000);
      chk("prime_level", fifo_level, 2);
      wait_pv(n);
      chk("p1_left", pcm_left, 16'h1000);
      chk("p1_right", pcm_right, 16'hF000);
      chk("p1_level", fifo_level, 1);
      wait_pv(n);
      chk("p2_gap", n, 4);
      chk("p2_left", pcm_left, 16'h2000);
      chk("p2_right", pcm_right, 16'hE000);
      chk("p2_level", fifo_level, 0);
      wait_pv(n);
      chk("ur_gap", n, 4);
      chk("ur_flag", underrun, 1);
`ifdef AUDIO_SCHEDULER_SOFT_MUTE_EN
      chk("ur_left", pcm_left, 16'h1000);
      chk("ur_right", pcm_right, 16'hF000);
      wait_pv(n);
      chk("ur2_left", pcm_left, 16'h0800);
      chk("ur2_right", pcm_right, 16'hF800);
`else
      chk("ur_left", pcm_left, 16'h2000);
      chk("ur_right", pcm_right, 16'hE000);
`endif

      // fill while idle, then drain at divider=0
      enable = 1'b0;
      do_flush();
      chk("ur_cleared", underrun, 0);
      sample_valid = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         sample_left = 16'(k); sample_right = 16'hF000 | 16'(k);
         cyc(1);
      end
      sample_valid = 1'b0;
      chk("full_ready", sample_ready, 0);
      chk("full_level", fifo_level, 4);
      enable = 1'b1; divider = 0;
      wait_pv(n);
      chk("d1_left", pcm_left, 1);
      chk("d1_ready", sample_ready, 1);
      for (int j = 2; j <= 4; j++) begin
         cyc(1);
         chk("dn_pv", pcm_valid, 1);
         chk("dn_left", pcm_left, j);
         chk("dn_right", pcm_right, 16'hF000 | 16'(j));
      end

      // flush at level 3 while pushing
      enable = 1'b0;
      do_flush();
      divider = 20; enable = 1'b1;
      push_one(16'h0A01, 16'h0B01);
      push_one(16'h0A02, 16'h0B02);
      push_one(16'h0A03, 16'h0B03);
      chk("fl_pre_level", fifo_level, 3);
      flush = 1'b1; sample_valid = 1'b1; sample_left = 16'h0A04;
      cyc(1);
      flush = 1'b0; sample_valid = 1'b0;
      chk("fl_level", fifo_level, 0);
      cnt = 0;
      push_one(16'h0C01, 16'h0D01);
      repeat (30) begin cyc(1); if (pcm_valid) cnt++; end
      chk("fl_no_pv", cnt, 0);
      push_one(16'h0C02, 16'h0D02);
      wait_pv(n);
      chk("fl_next_left", pcm_left, 16'h0C01);
      chk("fl_next_right", pcm_right, 16'h0D01);

      // divider change mid-period
      enable = 1'b0;
      do_flush();
      divider = 7; enable = 1'b1;
      for (int k = 0; k < 4; k++) push_one(16'h3000 + 16'(k), 16'h4000 + 16'(k));
      wait_pv(n);
      cyc(3);
      divider = 1;
      wait_pv(n);
      chk("div_old_period", n, 5);
      wait_pv(n);
      chk("div_new_period", n, 2);

      // asynchronous reset between edges
      #2 reset_n = 1'b0;
      #1;
      chk("arst_left", pcm_left, 0);
      chk("arst_right", pcm_right, 0);
      chk("arst_ready", sample_ready, 0);
      chk("arst_pv", pcm_valid, 0);
      enable = 1'b0;
      cyc(1);
      reset_n = 1'b1;
      cyc(1);
      chk("arst_level", fifo_level, 0);
      push_one(16'h5555, 16'hAAAA);
      cnt = 0;
      repeat (10) begin cyc(1); if (pcm_valid) cnt++; end
      chk("arst_idle_pv", cnt, 0);
      chk("arst_idle_level", fifo_level, 1);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         reset_n        = ($urandom_range(0, 299) != 0);
         enable         = ($urandom_range(0, 19) != 0);
         flush          = ($urandom_range(0, 49) == 0);
         sample_valid   = $urandom_range(0, 1);
         sample_left    = W'($urandom);
         sample_right   = W'($urandom);
         underrun_clear = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 31) == 0) divider = DW'($urandom_range(0, 5));
         cyc(1);
      end
      reset_n = 1'b1;
      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/audio_sample_scheduler.md
Name: audio_sample_scheduler

Overview:
- Sequences stereo PCM delivery into the two pdm_dac instances (left/right).
- Accepts signed stereo sample pairs from the audio producer over a valid/ready handshake and buffers them in a small FIFO.
- Issues one pcm_valid strobe per sample period, derived from a programmable clock divider.
- Handles startup priming, underrun and flush, so the DACs always get a well-defined sample stream.

Parameters:
- WIDTH, 16, sample width per channel (signed two's complement).
- DIVIDER_WIDTH, 12, width of the sample-period divider.
- FIFO_DEPTH_LOG2, 2, log2 of FIFO depth in stereo pairs (default depth 4).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run sample scheduling
- flush  in  1  synchronous FIFO clear, single cycle
- divider  in  DIVIDER_WIDTH  clocks per sample minus 1
- sample_left  in  WIDTH  left sample, signed
- sample_right  in  WIDTH  right sample, signed
- sample_valid  in  1  producer has a pair
- sample_ready  out  1  FIFO can accept a pair
- pcm_left  out  WIDTH  left sample to DAC
- pcm_right  out  WIDTH  right sample to DAC
- pcm_valid  out  1  one-cycle strobe per sample period
- underrun  out  1  sticky; set on a tick with FIFO empty
- underrun_clear  in  1  clears underrun
- fifo_level  out  FIFO_DEPTH_LOG2+1  pairs currently buffered

Behaviour:
- Reset (async, reset_n=0):
  - FIFO empty, state IDLE, counter 0.
  - pcm_left/pcm_right 0, pcm_valid 0, underrun 0.
  - sample_ready 0 while reset is asserted.
- Push: occurs when sample_valid && sample_ready. sample_ready = !full && reset_n, combinational from registered level.
- Pop: occurs only on an internal tick. Push and pop in the same cycle is legal; the level is unchanged.
- Pointers wrap modulo depth. fifo_level ranges 0..2^FIFO_DEPTH_LOG2.
- flush:
  - Next cycle: level 0 and pointers 0.
  - Has priority over a same-cycle push and pop; both are discarded.
  - State forced to PRIME if enable=1, else IDLE.
- States:
  - IDLE: no ticks; counter held at 0; FIFO still accepts. enable=1 -> PRIME.
  - PRIME: no ticks. When level >= depth/2, go to RUN and load counter with divider. enable=0 -> IDLE.
  - RUN: counter decrements each cycle. At counter==0, tick and reload from the current divider. enable=0 -> IDLE; the FIFO contents are retained.
- Timing: first tick occurs divider+1 cycles after entering RUN. divider=0 gives a tick every cycle. A divider change takes effect at the next reload.
- Tick with FIFO non-empty: the next cycle pcm_left/pcm_right = head pair, pcm_valid=1 for exactly one cycle, head popped. Latency tick->pcm_valid is 1 cycle.
- Tick with FIFO empty:
  - underrun set.
  - pcm_valid still pulses; held value per Optional Feature.
  - State stays RUN; the scheduler does not re-prime.
- underrun stays set until underrun_clear. If set and clear occur in the same cycle, set wins.
- pcm_left/pcm_right change only on a pcm_valid cycle.
- Reset mid-operation: all state discarded immediately. A pcm_valid in flight is lost.

Optional Feature:
- Macro: AUDIO_SCHEDULER_SOFT_MUTE_EN.
- Defined: on each underrun tick, each channel's output becomes its previous value arithmetic-shifted right by 1. If the result is -1, it becomes 0. The output therefore decays to 0 within WIDTH ticks, with no DC step.
- Undefined: on underrun, outputs repeat the last delivered pair unchanged (0 if none since reset).

Test Plan:
- Reset: divider=3, enable=1, push pairs (0x1000,0xF000) then (0x2000,0xE000); enter RUN when level=2. Required: pcm_valid pulses every 4 cycles; outputs 0x1000/0xF000 then 0x2000/0xE000; level steps 2 -> 1 -> 0.
- FIFO full:
  - Hold sample_valid with enable=0; sample_ready drops after 4 pushes and fifo_level=4.
  - Then enable=1, divider=0: four pcm_valid pulses on consecutive cycles, in order.
  - sample_ready returns 1 the cycle after the first pop.
- Underrun: with an empty FIFO in RUN, last pair (0x0100,0xFF00), next tick.
  - underrun=1 and pcm_valid pulses.
  - Without the macro, outputs hold 0x0100/0xFF00.
  - With the macro, outputs are 0x0080/0xFF80, then 0x0040/0xFFC0, and reach 0 after 9 underrun ticks.
- Flush with level 3 while pushing: next cycle level=0, no pcm_valid from flushed data; state returns to PRIME and requires 2 pushes before the next tick.
- Divider change: RUN with divider=7, change to 1 mid-period; the current period completes at 8 cycles, and following periods are 2 cycles.
- Async reset asserted mid-RUN between edges: outputs go to 0 immediately and sample_ready=0. After release, fifo_level=0 and the state is IDLE.
